ocp_slave_mem: RTL and testbench

//  OCP 2.2 slave target that sits directly downstream of ocp_master_fsm on the OCP bus.

---
 rtl/ocp_slave_mem.sv | 198 +++++++++++++++++++
 tb/tb_ocp_slave_mem.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ocp_slave_mem.sv
// OCP slave target: word memory behind an accept FSM, with a protocol checker.
// Latency: write lands at the accept edge; read response valid RESP_LATENCY edges after accept.
// Backpressure: optional ACCEPT_WAIT stall before the first beat of a burst; responses never stall.
module ocp_slave_mem #(
  parameter int MADDR_WIDTH  = 64,
  parameter int MDATA_WIDTH  = 8,
  parameter int SDATA_WIDTH  = 8,
  parameter int MEM_DEPTH    = 16,
  parameter int ADDR_SHIFT   = 2,
  parameter int ACCEPT_WAIT  = 0,
  parameter int RESP_LATENCY = 1
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   EnableClk,
  input  logic [2:0]             MCmd,
  input  logic [MADDR_WIDTH-1:0] MAddr,
  input  logic [MDATA_WIDTH-1:0] MData,
  input  logic [9:0]             MBurstLength,
  input  logic                   MReqLast,
  output logic                   SCmdAccept,
  output logic [1:0]             SResp,
  output logic                   SRespLast,
  output logic [SDATA_WIDTH-1:0] SData,
  output logic                   protocol_err
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = (ACCEPT_WAIT > 0) ? 4'(ACCEPT_WAIT - 1) : 4'd0;

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;
  localparam logic [2:0] CMD_RDEX = 3'b011;
  localparam logic [2:0] CMD_RDL  = 3'b100;
  localparam logic [2:0] CMD_WRNP = 3'b101;
  localparam logic [2:0] CMD_WRC  = 3'b110;
  localparam logic [2:0] CMD_BCST = 3'b111;

  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BURST} state_t;

  typedef struct packed {
    logic [1:0]             resp;
    logic                   last;
    logic [SDATA_WIDTH-1:0] data;
  } resp_t;

  state_t                 state;
  logic [3:0]             wait_cnt;
  logic [MDATA_WIDTH-1:0] mem [MEM_DEPTH];
  resp_t                  pipe [RESP_LATENCY];
  resp_t                  new_rsp;

  logic [MADDR_WIDTH-1:0] idx_full;
  logic [IDX_W-1:0]       idx;
  logic                   in_range;
  logic                   req_vld;
  logic                   do_write;

  logic [10:0]            beat_cnt;
  logic [10:0]            beat_num;
  logic [9:0]             eff_len;
  logic [2:0]             burst_cmd;
  logic [9:0]             burst_len;
  logic                   in_burst;
  logic                   viol;

  // Address decode; the range check uses every address bit so high bits cannot alias.
  assign idx_full = MAddr >> ADDR_SHIFT;
  assign idx      = idx_full[IDX_W-1:0];
  assign in_range = idx_full < MADDR_WIDTH'(MEM_DEPTH);
  assign req_vld  = MCmd != CMD_IDLE;
  assign do_write = (MCmd == CMD_WR) || (MCmd == CMD_BCST) || (MCmd == CMD_WRNP);

  // Accept decision straight from state, wait counter and the presented command.
  always_comb begin
    SCmdAccept = 1'b0;
    if (EnableClk && req_vld) begin
      case (state)
        ST_IDLE:  SCmdAccept = (ACCEPT_WAIT == 0);
        ST_WAIT:  SCmdAccept = (wait_cnt == 4'd0);
        ST_BURST: SCmdAccept = 1'b1;
        default:  SCmdAccept = 1'b0;
      endcase
    end
  end

  // Accept FSM: optional stall before the first beat, then stall-free burst beats.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else if (EnableClk) begin
      case (state)
        ST_IDLE: begin
          if (req_vld) begin
            if (ACCEPT_WAIT == 0) begin
              if (!MReqLast) state <= ST_BURST;
            end else begin
              wait_cnt <= WAIT_INIT;
              state    <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!req_vld)               state    <= ST_IDLE;
          else if (wait_cnt != 4'd0)  wait_cnt <= wait_cnt - 4'd1;
          else                        state    <= MReqLast ? ST_IDLE : ST_BURST;
        end
        ST_BURST: begin
          if (req_vld && MReqLast) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory: cleared by reset, written at the accept edge for in-range writes.
  always_ff @(posedge Clk) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (SCmdAccept && do_write && in_range) begin
      mem[idx] <= MData;
    end
  end

  // Response for the beat being accepted this cycle; all-zero means no response.
  always_comb begin
    new_rsp = '0;
    if (SCmdAccept) begin
      case (MCmd)
        CMD_RD, CMD_RDEX, CMD_RDL: begin
          new_rsp.resp = in_range ? RESP_DVA : RESP_ERR;
          new_rsp.data = in_range ? SDATA_WIDTH'(mem[idx]) : '0;
          new_rsp.last = MReqLast;
        end
        CMD_WRNP: begin
          new_rsp.resp = in_range ? RESP_DVA : RESP_ERR;
          new_rsp.last = MReqLast;
        end
        CMD_WRC: begin
          new_rsp.resp = RESP_ERR;
          new_rsp.last = MReqLast;
        end
        default: new_rsp = '0;
      endcase
    end
  end

  // Fixed-latency response shift register; the last stage drives the bus.
  always_ff @(posedge Clk) begin
    if (reset) begin
      for (int i = 0; i < RESP_LATENCY; i++) pipe[i] <= '0;
    end else if (EnableClk) begin
      pipe[0] <= new_rsp;
      for (int i = 1; i < RESP_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign SResp     = pipe[RESP_LATENCY-1].resp;
  assign SRespLast = pipe[RESP_LATENCY-1].last;
  assign SData     = pipe[RESP_LATENCY-1].data;

  // Protocol checker over accepted beats; a zero length is treated as one.
  assign eff_len  = (MBurstLength == 10'd0) ? 10'd1 : MBurstLength;
  assign beat_num = beat_cnt + 11'd1;
  assign in_burst = beat_cnt != 11'd0;
  assign viol     = (MBurstLength == 10'd0)
                  || ( MReqLast && (beat_num != {1'b0, eff_len}))
                  || (!MReqLast && (beat_num == {1'b0, eff_len}))
                  || (in_burst && ((MCmd != burst_cmd) || (MBurstLength != burst_len)));

  // Beat counting and the sticky violation flag.
  always_ff @(posedge Clk) begin
    if (reset) begin
      beat_cnt     <= 11'd0;
      burst_cmd    <= CMD_IDLE;
      burst_len    <= 10'd0;
      protocol_err <= 1'b0;
    end else if (SCmdAccept) begin
      if (viol) protocol_err <= 1'b1;
      if (MReqLast) begin
        beat_cnt <= 11'd0;
      end else begin
        beat_cnt <= beat_num;
        if (!in_burst) begin
          burst_cmd <= MCmd;
          burst_len <= MBurstLength;
        end
      end
    end
  end

endmodule

// File: tb/tb_ocp_slave_mem.sv
// Directed bench: dut_a has no accept wait and one-edge latency, dut_b has
// three wait cycles and three-edge latency. Both share the request bus and
// are selected by their own EnableClk.
module tb_ocp_slave_mem;

  localparam logic [2:0] C_IDLE = 3'b000, C_WR = 3'b001, C_RD = 3'b010, C_RDEX = 3'b011;
  localparam logic [2:0] C_RDL = 3'b100, C_WRNP = 3'b101, C_WRC = 3'b110, C_BCST = 3'b111;
  localparam logic [1:0] R_NULL = 2'b00, R_DVA = 2'b01, R_ERR = 2'b11;

  logic        clk = 1'b0;
  logic        reset, en_a, en_b;
  logic [2:0]  mcmd;
  logic [63:0] maddr;
  logic [7:0]  mdata;
  logic [9:0]  mblen;
  logic        mlast;

  logic       acc_a, last_a, perr_a, acc_b, last_b, perr_b;
  logic [1:0] resp_a, resp_b;
  logic [7:0] data_a, data_b;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0]  c;
    logic [63:0] a;
    logic [7:0]  d;
    logic [1:0]  r;
    logic [7:0]  x;
  } vec_t;

  vec_t dec_tbl [14] = '{
    '{C_RD,   64'h100,         8'h00, R_ERR,  8'h00},
    '{C_WRC,  64'h0,           8'hAA, R_ERR,  8'h00},
    '{C_RD,   64'h0,           8'h00, R_DVA,  8'h00},
    '{C_WR,   64'h3C,          8'h3C, R_NULL, 8'h00},
    '{C_RD,   64'h3C,          8'h00, R_DVA,  8'h3C},
    '{C_WR,   64'h40,          8'h55, R_NULL, 8'h00},
    '{C_RD,   64'h0,           8'h00, R_DVA,  8'h00},
    '{C_WRNP, 64'h8,           8'h5A, R_DVA,  8'h00},
    '{C_RD,   64'h8,           8'h00, R_DVA,  8'h5A},
    '{C_BCST, 64'hC,           8'h77, R_NULL, 8'h00},
    '{C_RDEX, 64'hC,           8'h00, R_DVA,  8'h77},
    '{C_RDL,  64'h4,           8'h00, R_DVA,  8'h01},
    '{C_WRNP, 64'h44,          8'h12, R_ERR,  8'h00},
    '{C_RD,   64'h1_0000_0004, 8'h00, R_ERR,  8'h00}
  };

  ocp_slave_mem #(.ACCEPT_WAIT(0), .RESP_LATENCY(1)) dut_a (
    .Clk(clk), .reset(reset), .EnableClk(en_a), .MCmd(mcmd), .MAddr(maddr), .MData(mdata),
    .MBurstLength(mblen), .MReqLast(mlast), .SCmdAccept(acc_a), .SResp(resp_a),
    .SRespLast(last_a), .SData(data_a), .protocol_err(perr_a));

  ocp_slave_mem #(.ACCEPT_WAIT(3), .RESP_LATENCY(3)) dut_b (
    .Clk(clk), .reset(reset), .EnableClk(en_b), .MCmd(mcmd), .MAddr(maddr), .MData(mdata),
    .MBurstLength(mblen), .MReqLast(mlast), .SCmdAccept(acc_b), .SResp(resp_b),
    .SRespLast(last_b), .SData(data_b), .protocol_err(perr_b));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] c, input logic [63:0] a, input logic [7:0] d,
                       input logic [9:0] l, input logic lst);
    mcmd = c; maddr = a; mdata = d; mblen = l; mlast = lst;
  endtask

  task automatic idle();
    drive(C_IDLE, 64'h0, 8'h0, 10'd1, 1'b0);
  endtask

  task automatic do_reset();
    logic sa, sb;
    sa = en_a; sb = en_b;
    reset = 1'b1; en_a = 1'b1; en_b = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0; en_a = sa; en_b = sb;
  endtask

  // Single-beat transaction on dut_a; returns accept and the response one edge later.
  task automatic a_single(input logic [2:0] c, input logic [63:0] a, input logic [7:0] d,
                          output logic acc, output logic [10:0] rsp);
    drive(c, a, d, 10'd1, 1'b1);
    #1 acc = acc_a;
    step();
    idle();
    rsp = {resp_a, last_a, data_a};
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if ({acc_a, resp_a, last_a, data_a, perr_a} !== 13'h0) begin miscompares++; $display("FAIL reset_a got=%h exp=%h", {acc_a, resp_a, last_a, data_a, perr_a}, 13'h0); end
    vectors++; if ({acc_b, resp_b, last_b, data_b, perr_b} !== 13'h0) begin miscompares++; $display("FAIL reset_b got=%h exp=%h", {acc_b, resp_b, last_b, data_b, perr_b}, 13'h0); end
  endtask

  task automatic test_single_wr_rd();
    en_a = 1'b1; en_b = 1'b0;
    drive(C_WR, 64'h4, 8'hFF, 10'd1, 1'b1);
    #1; vectors++; if (acc_a !== 1'b1) begin miscompares++; $display("FAIL wr_accept got=%b exp=1", acc_a); end
    step();
    vectors++; if (resp_a !== R_NULL) begin miscompares++; $display("FAIL wr_no_resp got=%h exp=%h", resp_a, R_NULL); end
    drive(C_RD, 64'h4, 8'h00, 10'd1, 1'b1);
    #1; vectors++; if (acc_a !== 1'b1) begin miscompares++; $display("FAIL rd_accept got=%b exp=1", acc_a); end
    step();
    idle();
    vectors++; if ({resp_a, last_a, data_a} !== {R_DVA, 1'b1, 8'hFF}) begin miscompares++; $display("FAIL rd_resp got=%h exp=%h", {resp_a, last_a, data_a}, {R_DVA, 1'b1, 8'hFF}); end
    step();
    vectors++; if ({resp_a, last_a, data_a} !== 11'h0) begin miscompares++; $display("FAIL rd_resp_one_cycle got=%h exp=0", {resp_a, last_a, data_a}); end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 4; i++) begin
      drive(C_WR, 64'(4 * i), 8'(i), 10'd4, i == 3);
      #1; vectors++; if (acc_a !== 1'b1) begin miscompares++; $display("FAIL bwr_accept beat=%0d got=%b exp=1", i, acc_a); end
      step();
    end
    for (int i = 0; i <= 4; i++) begin
      if (i == 0) begin
        vectors++; if (resp_a !== R_NULL) begin miscompares++; $display("FAIL brd_pre got=%h exp=0", resp_a); end
      end else begin
        vectors++; if ({resp_a, last_a, data_a} !== {R_DVA, i == 4, 8'(i - 1)}) begin miscompares++; $display("FAIL brd_resp beat=%0d got=%h exp=%h", i - 1, {resp_a, last_a, data_a}, {R_DVA, i == 4, 8'(i - 1)}); end
      end
      if (i < 4) begin
        drive(C_RD, 64'(4 * i), 8'h00, 10'd4, i == 3);
        #1; vectors++; if (acc_a !== 1'b1) begin miscompares++; $display("FAIL brd_accept beat=%0d got=%b exp=1", i, acc_a); end
      end else begin
        idle();
      end
      step();
    end
    vectors++; if ({resp_a, last_a, data_a} !== 11'h0) begin miscompares++; $display("FAIL brd_post got=%h exp=0", {resp_a, last_a, data_a}); end
  endtask

  task automatic test_decode();
    logic acc;
    logic [10:0] rsp;
    logic [10:0] exp_rsp;
    for (int i = 0; i < 14; i++) begin
      a_single(dec_tbl[i].c, dec_tbl[i].a, dec_tbl[i].d, acc, rsp);
      exp_rsp = {dec_tbl[i].r, dec_tbl[i].r != R_NULL, dec_tbl[i].x};
      vectors++; if (acc !== 1'b1) begin miscompares++; $display("FAIL dec_accept row=%0d got=%b exp=1", i, acc); end
      vectors++; if (rsp !== exp_rsp) begin miscompares++; $display("FAIL dec_resp row=%0d got=%h exp=%h", i, rsp, exp_rsp); end
    end
  endtask

  task automatic test_enable();
    logic acc;
    logic [10:0] rsp;
    en_a = 1'b0;
    drive(C_WR, 64'h4, 8'hEE, 10'd1, 1'b1);
    #1; vectors++; if (acc_a !== 1'b0) begin miscompares++; $display("FAIL en_low_accept got=%b exp=0", acc_a); end
    step();
    idle();
    en_a = 1'b1;
    a_single(C_RD, 64'h4, 8'h00, acc, rsp);
    vectors++; if (rsp !== {R_DVA, 1'b1, 8'h01}) begin miscompares++; $display("FAIL en_low_no_write got=%h exp=%h", rsp, {R_DVA, 1'b1, 8'h01}); end
  endtask

  task automatic test_protocol();
    logic acc;
    logic [10:0] rsp;
    vectors++; if (perr_a !== 1'b0) begin miscompares++; $display("FAIL perr_start got=%b exp=0", perr_a); end
    for (int i = 0; i < 3; i++) begin
      drive(C_WR, 64'(32 + 4 * i), 8'(i), 10'd4, i == 2);
      step();
      vectors++; if (perr_a !== (i == 2)) begin miscompares++; $display("FAIL perr_early_last beat=%0d got=%b exp=%b", i, perr_a, i == 2); end
    end
    idle();
    step(); step(); step();
    vectors++; if (perr_a !== 1'b1) begin miscompares++; $display("FAIL perr_sticky got=%b exp=1", perr_a); end
    a_single(C_RD, 64'h24, 8'h00, acc, rsp);
    vectors++; if (rsp !== {R_DVA, 1'b1, 8'h01}) begin miscompares++; $display("FAIL perr_transfer got=%h exp=%h", rsp, {R_DVA, 1'b1, 8'h01}); end
    do_reset();
    vectors++; if (perr_a !== 1'b0) begin miscompares++; $display("FAIL perr_reset got=%b exp=0", perr_a); end
    drive(C_WR, 64'h0, 8'h00, 10'd0, 1'b1);
    step(); idle();
    vectors++; if (perr_a !== 1'b1) begin miscompares++; $display("FAIL perr_len0 got=%b exp=1", perr_a); end
    do_reset();
    drive(C_WR, 64'h0, 8'h00, 10'd2, 1'b0);
    step();
    vectors++; if (perr_a !== 1'b0) begin miscompares++; $display("FAIL perr_cmd_beat0 got=%b exp=0", perr_a); end
    drive(C_RD, 64'h4, 8'h00, 10'd2, 1'b1);
    step(); idle();
    vectors++; if (perr_a !== 1'b1) begin miscompares++; $display("FAIL perr_cmd_change got=%b exp=1", perr_a); end
    do_reset();
    drive(C_WR, 64'h0, 8'h00, 10'd2, 1'b0); step();
    drive(C_WR, 64'h4, 8'h00, 10'd2, 1'b1); step(); idle();
    vectors++; if (perr_a !== 1'b0) begin miscompares++; $display("FAIL perr_clean_burst got=%b exp=0", perr_a); end
    drive(C_WR, 64'h0, 8'h00, 10'd1, 1'b0); step(); idle();
    vectors++; if (perr_a !== 1'b1) begin miscompares++; $display("FAIL perr_missing_last got=%b exp=1", perr_a); end
    do_reset();
  endtask

  task automatic test_wait_burst();
    en_a = 1'b0; en_b = 1'b1;
    drive(C_WR, 64'h0, 8'h10, 10'd4, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1; vectors++; if (acc_b !== 1'b0) begin miscompares++; $display("FAIL wwr_stall cyc=%0d got=%b exp=0", k, acc_b); end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(C_WR, 64'(4 * i), 8'(16 + i), 10'd4, i == 3);
      #1; vectors++; if (acc_b !== 1'b1) begin miscompares++; $display("FAIL wwr_accept beat=%0d got=%b exp=1", i, acc_b); end
      step();
    end
    drive(C_RD, 64'h0, 8'h00, 10'd4, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1; vectors++; if (acc_b !== 1'b0) begin miscompares++; $display("FAIL wrd_stall cyc=%0d got=%b exp=0", k, acc_b); end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(C_RD, 64'(4 * i), 8'h00, 10'd4, i == 3);
      #1; vectors++; if (acc_b !== 1'b1) begin miscompares++; $display("FAIL wrd_accept beat=%0d got=%b exp=1", i, acc_b); end
      step();
      if (i >= 2) begin
        vectors++; if ({resp_b, last_b, data_b} !== {R_DVA, 1'b0, 8'(14 + i)}) begin miscompares++; $display("FAIL wrd_resp beat=%0d got=%h exp=%h", i - 2, {resp_b, last_b, data_b}, {R_DVA, 1'b0, 8'(14 + i)}); end
      end else begin
        vectors++; if (resp_b !== R_NULL) begin miscompares++; $display("FAIL wrd_early cyc=%0d got=%h exp=0", i, resp_b); end
      end
    end
    idle();
    step();
    vectors++; if ({resp_b, last_b, data_b} !== {R_DVA, 1'b0, 8'h12}) begin miscompares++; $display("FAIL wrd_resp beat=2 got=%h exp=%h", {resp_b, last_b, data_b}, {R_DVA, 1'b0, 8'h12}); end
    step();
    vectors++; if ({resp_b, last_b, data_b} !== {R_DVA, 1'b1, 8'h13}) begin miscompares++; $display("FAIL wrd_resp beat=3 got=%h exp=%h", {resp_b, last_b, data_b}, {R_DVA, 1'b1, 8'h13}); end
    step();
    vectors++; if ({resp_b, last_b, data_b} !== 11'h0) begin miscompares++; $display("FAIL wrd_post got=%h exp=0", {resp_b, last_b, data_b}); end
    vectors++; if (perr_b !== 1'b0) begin miscompares++; $display("FAIL wait_perr got=%b exp=0", perr_b); end
  endtask

  task automatic test_reset_mid_burst();
    en_a = 1'b0; en_b = 1'b1;
    drive(C_RD, 64'h0, 8'h00, 10'd4, 1'b0);
    step(); step(); step();
    for (int i = 0; i < 2; i++) begin
      drive(C_RD, 64'(4 * i), 8'h00, 10'd4, 1'b0);
      #1; vectors++; if (acc_b !== 1'b1) begin miscompares++; $display("FAIL mid_accept beat=%0d got=%b exp=1", i, acc_b); end
      step();
    end
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
    vectors++; if ({resp_b, last_b, data_b} !== 11'h0) begin miscompares++; $display("FAIL mid_reset_resp got=%h exp=0", {resp_b, last_b, data_b}); end
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++; if (resp_b !== R_NULL) begin miscompares++; $display("FAIL mid_stale cyc=%0d got=%h exp=0", k, resp_b); end
    end
    drive(C_RD, 64'h0, 8'h00, 10'd1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1; vectors++; if (acc_b !== 1'b0) begin miscompares++; $display("FAIL post_stall cyc=%0d got=%b exp=0", k, acc_b); end
      step();
    end
    #1; vectors++; if (acc_b !== 1'b1) begin miscompares++; $display("FAIL post_accept got=%b exp=1", acc_b); end
    step();
    idle();
    step(); step();
    vectors++; if ({resp_b, last_b, data_b} !== {R_DVA, 1'b1, 8'h00}) begin miscompares++; $display("FAIL post_resp got=%h exp=%h", {resp_b, last_b, data_b}, {R_DVA, 1'b1, 8'h00}); end
    step();
    vectors++; if ({resp_b, last_b, data_b} !== 11'h0) begin miscompares++; $display("FAIL post_resp_one_cycle got=%h exp=0", {resp_b, last_b, data_b}); end
  endtask

  initial begin
    reset = 1'b1; en_a = 1'b1; en_b = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_single_wr_rd();
    test_burst();
    test_decode();
    test_enable();
    test_protocol();
    test_wait_burst();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
